// File: rtl/data_mem_arbiter_if.sv
// Requester/memory bus bundle for data_mem_arbiter: two req/gnt/done requester
// ports plus the data_mem side. slave = arbiter view, master = requester/memory view.
interface data_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              word_we0;
  logic              byte_we0;
  logic              gnt0;
  logic              done0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              word_we1;
  logic              byte_we1;
  logic              gnt1;
  logic              done1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_word_we;
  logic              mem_byte_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, addr0, wdata0, word_we0, byte_we0,
    input  req1, addr1, wdata1, word_we1, byte_we1,
    input  mem_rdata,
    output gnt0, done0, rdata0, gnt1, done1, rdata1,
    output mem_addr, mem_wdata, mem_word_we, mem_byte_we
  );

  modport master (
    output req0, addr0, wdata0, word_we0, byte_we0,
    output req1, addr1, wdata1, word_we1, byte_we1,
    output mem_rdata,
    input  gnt0, done0, rdata0, gnt1, done1, rdata1,
    input  mem_addr, mem_wdata, mem_word_we, mem_byte_we
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter for the single-ported data memory (IDLE/BUSY/DONE).
// Define DATA_MEM_ARB_CPU_PRIORITY_EN for strict requester-0 priority instead of round-robin.
module data_mem_arbiter #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic               clock,
  input  logic               reset,
  data_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t            state_q, state_d;
  logic              winner_q, winner_d;
  logic              last_q, last_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wwe_q, wwe_d;
  logic              bwe_q, bwe_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              req_any;
  logic              pick;
  logic              last_beat;

  always_comb begin
    req_any = bus.req0 | bus.req1;
`ifdef DATA_MEM_ARB_CPU_PRIORITY_EN
    pick = ~bus.req0;
`else
    pick = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
`endif
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wwe_d    = wwe_q;
    bwe_d    = bwe_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d  = BUSY;
          winner_d = pick;
          cnt_d    = CNT_INIT;
          addr_d   = pick ? bus.addr1    : bus.addr0;
          wdata_d  = pick ? bus.wdata1   : bus.wdata0;
          wwe_d    = pick ? bus.word_we1 : bus.word_we0;
          // a word write wins over a simultaneous byte write
          bwe_d    = (pick ? bus.byte_we1 : bus.byte_we0) & ~wwe_d;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (winner_q) rdata1_d = bus.mem_rdata;
          else          rdata0_d = bus.mem_rdata;
          last_d  = winner_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      winner_q <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wwe_q    <= 1'b0;
      bwe_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wwe_q    <= wwe_d;
      bwe_q    <= bwe_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign last_beat = (state_q == BUSY) && (cnt_q == '0);

  assign bus.gnt0        = (state_q == IDLE) & req_any & ~pick;
  assign bus.gnt1        = (state_q == IDLE) & req_any &  pick;
  assign bus.done0       = (state_q == DONE) & ~winner_q;
  assign bus.done1       = (state_q == DONE) &  winner_q;
  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;
  // DONE keeps the latched address/data on the bus; only IDLE drives zero
  assign bus.mem_addr    = (state_q == IDLE) ? '0 : addr_q;
  assign bus.mem_wdata   = (state_q == IDLE) ? '0 : wdata_q;
  assign bus.mem_word_we = last_beat & wwe_q;
  assign bus.mem_byte_we = last_beat & bwe_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: random and directed requests, a
// transaction-level model predicts grants, memory writes and done/rdata.
module tb_data_mem_arbiter;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  data_mem_arbiter #(.LATENCY(LAT), .ADDR_W(32), .DATA_W(32)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 1) return 32'hDEADBEEF;
    return (32'(i) * 32'h01010101) ^ 32'hC0DE0000;
  endfunction

  // memory stand-in: combinational read, written on the clock edge
  logic [31:0] mem [16];
  bit          mem_loaded = 1'b0;
  assign bus.mem_rdata = mem[bus.mem_addr[5:2]];
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (bus.mem_word_we) begin
      mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
    end else if (bus.mem_byte_we) begin
      mem[bus.mem_addr[5:2]][7:0] <= bus.mem_wdata[7:0];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic outputs_nonzero();
    return bus.gnt0 | bus.gnt1 | bus.done0 | bus.done1 | (|bus.rdata0) | (|bus.rdata1) |
           (|bus.mem_addr) | (|bus.mem_wdata) | bus.mem_word_we | bus.mem_byte_we;
  endfunction

  // ---------------- reference model + monitor ----------------
  typedef struct { int cyc; bit who; logic [31:0] rdata; } done_t;
  typedef struct { int cyc; int idx; logic [31:0] addr; logic [31:0] data; bit word; bit bytew; } wr_t;

  done_t       dq[$];
  wr_t         wq[$];
  logic [31:0] refmem [16];
  bit          ref_loaded = 1'b0;
  bit          m_last = 1'b1;
  int          m_free_at = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;

  always @(negedge clk) begin
    bit          exp_g0, exp_g1, who, w, b;
    logic [31:0] a, d;
    wr_t         we;
    done_t       de;
    if (!ref_loaded) begin
      for (int i = 0; i < 16; i++) refmem[i] = init_word(i);
      ref_loaded = 1'b1;
    end
    if (rst) begin
      dq.delete();
      wq.delete();
      m_last    = 1'b1;
      m_free_at = 0;
      chk("reset_outputs_zero", 64'(outputs_nonzero()), 64'd0);
    end else begin
      // bus address/data: zero while idle, latched request otherwise
      if (cyc < m_free_at) begin
        chk("mem_addr_busy", 64'(bus.mem_addr), 64'(m_addr));
        chk("mem_wdata_busy", 64'(bus.mem_wdata), 64'(m_wdata));
      end else begin
        chk("mem_addr_idle", 64'({bus.mem_addr, bus.mem_wdata}), 64'd0);
      end

      exp_g0 = 1'b0;
      exp_g1 = 1'b0;
      if (cyc >= m_free_at && (bus.req0 || bus.req1)) begin
        if (bus.req0 && bus.req1) begin
`ifdef DATA_MEM_ARB_CPU_PRIORITY_EN
          who = 1'b0;
`else
          who = ~m_last;
`endif
        end else begin
          who = bus.req1;
        end
        if (who) begin exp_g1 = 1'b1; a = bus.addr1; d = bus.wdata1; w = bus.word_we1; b = bus.byte_we1; end
        else     begin exp_g0 = 1'b1; a = bus.addr0; d = bus.wdata0; w = bus.word_we0; b = bus.byte_we0; end
        de.cyc = cyc + LAT + 1; de.who = who; de.rdata = refmem[a[5:2]];
        dq.push_back(de);
        if (w || b) begin
          we.cyc = cyc + LAT; we.idx = int'(a[5:2]); we.addr = a; we.data = d;
          we.word = w; we.bytew = b && !w;
          wq.push_back(we);
        end
        m_last    = who;
        m_addr    = a;
        m_wdata   = d;
        m_free_at = cyc + LAT + 2;
      end
      if (bus.req0 || bus.req1 || bus.gnt0 || bus.gnt1) begin
        chk("gnt0", 64'(bus.gnt0), 64'(exp_g0));
        chk("gnt1", 64'(bus.gnt1), 64'(exp_g1));
      end

      // memory write: exactly one per write access, on its last BUSY cycle
      if (wq.size() > 0 && wq[0].cyc < cyc) begin
        chk("mem_write_missing", 64'd0, 64'd1);
        void'(wq.pop_front());
      end
      if (wq.size() > 0 && wq[0].cyc == cyc) begin
        we = wq.pop_front();
        chk("mem_word_we", 64'(bus.mem_word_we), 64'(we.word));
        chk("mem_byte_we", 64'(bus.mem_byte_we), 64'(we.bytew));
        chk("mem_write_addr", 64'(bus.mem_addr), 64'(we.addr));
        chk("mem_write_data", 64'(bus.mem_wdata), 64'(we.data));
        if (we.word) refmem[we.idx] = we.data;
        else         refmem[we.idx][7:0] = we.data[7:0];
      end else if (bus.mem_word_we || bus.mem_byte_we) begin
        chk("mem_we_unexpected", 64'({bus.mem_word_we, bus.mem_byte_we}), 64'd0);
      end

      // done pulse and returned data
      if (dq.size() > 0 && dq[0].cyc < cyc) begin
        chk("done_missing", 64'd0, 64'd1);
        void'(dq.pop_front());
      end
      if (dq.size() > 0 && dq[0].cyc == cyc) begin
        de = dq.pop_front();
        chk("done0", 64'(bus.done0), 64'(!de.who));
        chk("done1", 64'(bus.done1), 64'(de.who));
        chk(de.who ? "rdata1" : "rdata0", 64'(de.who ? bus.rdata1 : bus.rdata0), 64'(de.rdata));
      end else if (bus.done0 || bus.done1) begin
        chk("done_unexpected", 64'({bus.done0, bus.done1}), 64'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called just after a rising edge; holds the request until its grant is seen.
  task automatic issue(input bit who, input logic [31:0] a, input logic [31:0] d,
                       input bit w, input bit b, output int waited);
    bit got = 1'b0;
    waited = 0;
    if (!who) begin bus.req0 = 1'b1; bus.addr0 = a; bus.wdata0 = d; bus.word_we0 = w; bus.byte_we0 = b; end
    else      begin bus.req1 = 1'b1; bus.addr1 = a; bus.wdata1 = d; bus.word_we1 = w; bus.byte_we1 = b; end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (who ? bus.gnt1 : bus.gnt0) begin got = 1'b1; break; end
      waited++;
    end
    if (!got) chk("gnt_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    // inputs are don't-care after grant: scramble them
    if (!who) begin bus.req0 = 1'b0; bus.addr0 = $urandom; bus.wdata0 = $urandom; bus.word_we0 = 1'($urandom); bus.byte_we0 = 1'($urandom); end
    else      begin bus.req1 = 1'b0; bus.addr1 = $urandom; bus.wdata1 = $urandom; bus.word_we1 = 1'($urandom); bus.byte_we1 = 1'($urandom); end
  endtask

  function automatic logic [31:0] rand_addr();
    return {4'h1, 22'($urandom), 4'($urandom), 2'b00};
  endfunction

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_stream(input bit who, input int n);
    int wt;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      issue(who, rand_addr(), $urandom, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0), wt);
    end
  endtask

  initial begin
    int wt;
    bus.req0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0; bus.word_we0 = 1'b0; bus.byte_we0 = 1'b0;
    bus.req1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0; bus.word_we1 = 1'b0; bus.byte_we1 = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    repeat (5) begin
      @(negedge clk);
      chk("idle_outputs_zero", 64'(outputs_nonzero()), 64'd0);
    end
    idle_cycles(1);

    issue(1'b0, 32'h10000004, 32'h0, 1'b0, 1'b0, wt);          // single read
    idle_cycles(6);
    issue(1'b1, 32'h10000008, 32'h12345678, 1'b1, 1'b0, wt);   // single word write
    idle_cycles(6);
    issue(1'b0, 32'h1000000C, 32'hCAFEF00D, 1'b1, 1'b1, wt);   // both enables
    idle_cycles(6);
    issue(1'b1, 32'h10000014, 32'h000000A5, 1'b0, 1'b1, wt);   // byte write
    idle_cycles(6);

    fork                                                        // contention
      for (int k = 0; k < 6; k++) issue(1'b0, rand_addr(), $urandom, 1'b0, 1'b0, wt);
      begin
        int w1;
        for (int k = 0; k < 6; k++) issue(1'b1, rand_addr(), $urandom, 1'b1, 1'b0, w1);
      end
    join
    idle_cycles(6);

    // reset one cycle after the grant of a write
    issue(1'b0, 32'h10000010, 32'h55AA55AA, 1'b1, 1'b0, wt);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rdata0_after_reset", 64'(bus.rdata0), 64'd0);
    chk("done0_after_reset", 64'(bus.done0), 64'd0);
    idle_cycles(1);
    issue(1'b1, 32'h10000010, 32'h0, 1'b0, 1'b0, wt);          // read back: old value expected
    chk("post_reset_gnt1_wait", 64'(wt), 64'd0);
    idle_cycles(6);

    fork
      rand_stream(1'b0, 40);
      rand_stream(1'b1, 40);
    join

    for (int i = 0; i < 50 && (dq.size() > 0 || wq.size() > 0); i++) @(posedge clk);
    @(negedge clk);
    chk("queues_drained", 64'(dq.size() + wq.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
